// File: rtl/cache_switch_controller.sv
// Data-cache context-switch sequencer: stalls, drains memory, writes back dirty lines, swaps bank.
// Optional build macro CACHE_SWITCH_CYCLE_COUNT_EN adds a switch_cycles stall-length report.
module cache_switch_controller #(
  parameter  int NUM_CACHES = 4,
  parameter  int LINE_COUNT = 8,
  localparam int ID_W       = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1,
  localparam int IDX_W      = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  switch_req,
  input  logic [ID_W-1:0]       switch_target,
  input  logic                  d_mem_busy,
  input  logic [LINE_COUNT-1:0] dirty_vector,
  input  logic                  wb_ack,
  output logic                  wb_req,
  output logic [IDX_W-1:0]      wb_index,
  output logic                  stall,
  output logic [ID_W-1:0]       active_cache,
  output logic                  switch_done
`ifdef CACHE_SWITCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]           switch_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SCAN,
    S_WB_WAIT,
    S_SWAP,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   target_q, target_nxt;
  logic [IDX_W-1:0]  cnt_q, cnt_nxt;
  logic              wb_req_nxt;
  logic [IDX_W-1:0]  wb_index_nxt;
  logic [ID_W-1:0]   active_nxt;
  logic              stall_nxt;
  logic              done_nxt;
  logic              last_line;

  assign last_line = (cnt_q == IDX_W'(LINE_COUNT - 1));

  always_comb begin
    state_nxt    = state;
    target_nxt   = target_q;
    cnt_nxt      = cnt_q;
    wb_req_nxt   = wb_req;
    wb_index_nxt = wb_index;
    active_nxt   = active_cache;
    case (state)
      S_IDLE: begin
        if (switch_req) begin
          target_nxt = switch_target;
          state_nxt  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Switching to the bank already selected needs no drain or writeback.
        if (target_q == active_cache) begin
          state_nxt = S_DONE;
        end else if (!d_mem_busy) begin
          cnt_nxt   = '0;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (dirty_vector[cnt_q]) begin
          wb_req_nxt   = 1'b1;
          wb_index_nxt = cnt_q;
          state_nxt    = S_WB_WAIT;
        end else if (last_line) begin
          state_nxt = S_SWAP;
        end else begin
          cnt_nxt = cnt_q + IDX_W'(1);
        end
      end
      S_WB_WAIT: begin
        if (wb_req && wb_ack) begin
          wb_req_nxt = 1'b0;
          if (last_line) begin
            state_nxt = S_SWAP;
          end else begin
            cnt_nxt   = cnt_q + IDX_W'(1);
            state_nxt = S_SCAN;
          end
        end
      end
      S_SWAP: begin
        active_nxt = target_q;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they align with the state they describe.
    stall_nxt = state_nxt inside {S_DRAIN, S_SCAN, S_WB_WAIT, S_SWAP};
    done_nxt  = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      target_q     <= '0;
      cnt_q        <= '0;
      wb_req       <= 1'b0;
      wb_index     <= '0;
      stall        <= 1'b0;
      active_cache <= '0;
      switch_done  <= 1'b0;
    end else begin
      state        <= state_nxt;
      target_q     <= target_nxt;
      cnt_q        <= cnt_nxt;
      wb_req       <= wb_req_nxt;
      wb_index     <= wb_index_nxt;
      stall        <= stall_nxt;
      active_cache <= active_nxt;
      switch_done  <= done_nxt;
    end
  end

`ifdef CACHE_SWITCH_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  // Counts stalled cycles of the switch in flight; the request edge counts as the first.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q         <= '0;
      switch_cycles <= '0;
    end else begin
      if (state == S_IDLE && state_nxt == S_DRAIN) begin
        cyc_q <= 16'd1;
      end else if (stall_nxt && cyc_q != 16'hFFFF) begin
        cyc_q <= cyc_q + 16'd1;
      end
      if (done_nxt) begin
        switch_cycles <= cyc_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_switch_controller.sv
// Table-driven bench for cache_switch_controller with a writeback-index scoreboard.
module tb_cache_switch_controller;

  logic       clk;
  logic       reset;
  logic       switch_req;
  logic [1:0] switch_target;
  logic       d_mem_busy;
  logic [7:0] dirty_vector;
  logic       wb_ack;
  logic       wb_req;
  logic [2:0] wb_index;
  logic       stall;
  logic [1:0] active_cache;
  logic       switch_done;
`ifdef CACHE_SWITCH_CYCLE_COUNT_EN
  logic [15:0] switch_cycles;
`endif

  cache_switch_controller #(.NUM_CACHES(4), .LINE_COUNT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .switch_req    (switch_req),
    .switch_target (switch_target),
    .d_mem_busy    (d_mem_busy),
    .dirty_vector  (dirty_vector),
    .wb_ack        (wb_ack),
    .wb_req        (wb_req),
    .wb_index      (wb_index),
    .stall         (stall),
    .active_cache  (active_cache),
    .switch_done   (switch_done)
`ifdef CACHE_SWITCH_CYCLE_COUNT_EN
    ,
    .switch_cycles (switch_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] target;
    logic [7:0] dirty;
    int         busy;       // cycles d_mem_busy is sampled high in DRAIN
    int         ack_lat;    // cycles wb_req is seen high before wb_ack is raised
    bit         spur;       // drive wb_ack high whenever wb_req is low
    int         inj;        // cycle after request to pulse a second switch_req (0 = none)
    int         exp_stall;
    logic [1:0] exp_active;
  } vec_t;

  vec_t       vecs[9];
  vec_t       post_rst;
  int         checks = 0;
  int         errors = 0;
  int         sb_q[$];
  logic [1:0] model_active;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc, stall_cnt, done_cnt, wb_cyc, done_at, exp_idx;
    logic       prev_req;
    logic [2:0] held;
    if (v.target != model_active)
      for (int b = 0; b < 8; b++) if (v.dirty[b]) sb_q.push_back(b);
    @(negedge clk);
    switch_req    = 1'b1;
    switch_target = v.target;
    dirty_vector  = v.dirty;
    d_mem_busy    = (v.busy > 0);
    wb_ack        = 1'b0;
    cyc = 0; stall_cnt = 0; done_cnt = 0; wb_cyc = 0; done_at = 0;
    prev_req = 1'b0; held = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      switch_req    = (v.inj != 0 && cyc == v.inj);
      switch_target = v.target ^ 2'd1;
      d_mem_busy    = (cyc <= v.busy);
      if (stall) stall_cnt++;
      if (wb_req) begin
        if (!prev_req) begin
          wb_cyc = 0;
          held   = wb_index;
          if (sb_q.size() == 0) chk("wb_unexpected", 32'(wb_index), 32'hFFFF_FFFF);
          else begin
            exp_idx = sb_q.pop_front();
            chk("wb_index", 32'(wb_index), exp_idx);
          end
        end else begin
          chk("wb_index_hold", 32'(wb_index), 32'(held));
        end
        wb_ack = (wb_cyc == v.ack_lat);
        wb_cyc++;
      end else begin
        wb_ack = v.spur;
      end
      prev_req = wb_req;
      if (switch_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = cyc;
          chk("stall_at_done", 32'(stall), 0);
          chk("active_at_done", 32'(active_cache), 32'(v.exp_active));
          chk("stall_cycles", stall_cnt, v.exp_stall);
`ifdef CACHE_SWITCH_CYCLE_COUNT_EN
          chk("switch_cycles", 32'(switch_cycles), v.exp_stall);
`endif
        end
      end
      if (done_at != 0 && cyc >= done_at + 3) break;
      if (cyc > 300) begin
        chk("switch_timeout", 1, 0);
        break;
      end
    end
    switch_req = 1'b0;
    wb_ack     = 1'b0;
    d_mem_busy = 1'b0;
    chk("done_pulses", done_cnt, 1);
    chk("sb_empty", sb_q.size(), 0);
    chk("stall_after", 32'(stall), 0);
    sb_q.delete();
    model_active = v.target;
  endtask

  initial begin
    bit reached;
    vecs[0] = '{2'd2, 8'h00, 0, 0, 1'b0, 0, 10, 2'd2};   // clean bank
    vecs[1] = '{2'd2, 8'hFF, 0, 0, 1'b0, 0,  1, 2'd2};   // same bank: no writeback
    vecs[2] = '{2'd1, 8'h85, 0, 3, 1'b0, 0, 22, 2'd1};   // lines 0,2,7 dirty
    vecs[3] = '{2'd3, 8'h00, 5, 0, 1'b0, 0, 15, 2'd3};   // memory busy in drain
    vecs[4] = '{2'd0, 8'hFF, 0, 0, 1'b0, 0, 18, 2'd0};   // every line dirty, instant ack
    vecs[5] = '{2'd2, 8'h42, 0, 2, 1'b1, 0, 16, 2'd2};   // spurious acks between lines
    vecs[6] = '{2'd3, 8'h00, 0, 0, 1'b0, 4, 10, 2'd3};   // second request during SCAN
    vecs[7] = '{2'd1, 8'h00, 0, 0, 1'b0, 11, 10, 2'd1};  // second request during DONE
    vecs[8] = '{2'd1, 8'h01, 0, 1, 1'b0, 0,  1, 2'd1};   // same bank again
    post_rst = '{2'd0, 8'h10, 0, 0, 1'b0, 0, 1, 2'd0};   // reset cleared bank to 0

    reset = 1'b1; switch_req = 1'b0; switch_target = '0;
    d_mem_busy = 1'b0; dirty_vector = '0; wb_ack = 1'b0;
    model_active = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_req", 32'(wb_req), 0);
    chk("rst_wb_index", 32'(wb_index), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_active", 32'(active_cache), 0);
    chk("rst_done", 32'(switch_done), 0);
`ifdef CACHE_SWITCH_CYCLE_COUNT_EN
    chk("rst_switch_cycles", 32'(switch_cycles), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset while waiting on the writeback of line 2.
    @(negedge clk);
    switch_req    = 1'b1;
    switch_target = model_active ^ 2'd1;
    dirty_vector  = 8'h04;
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clk);
      switch_req = 1'b0;
      if (wb_req && wb_index == 3'd2) reached = 1'b1;
    end
    chk("reached_wb2", 32'(reached), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_wb_req", 32'(wb_req), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_active", 32'(active_cache), 0);
    chk("mid_rst_done", 32'(switch_done), 0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(switch_done), 0);
      chk("post_rst_stall", 32'(stall), 0);
    end
    model_active = '0;
    run_vec(post_rst);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
